// File: rtl/posit_frac_round.sv
// Posit fraction-field rounding: masks the extraction window to the field width implied by k and rounds the rest.
// Build with POSIT_ROUND_STATS_EN defined to add the saturating inexact-result counter.
module posit_frac_round #(
  parameter int IN_W      = 64,
  parameter int OUT_W     = 32,
  parameter int K_W       = 6,
  parameter int EXT_MSB   = 61,
  parameter int FRAC_BASE = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  mant_in,
  input  logic [K_W-1:0]   k_in,
  input  logic [1:0]       rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] mant_out,
  output logic             inexact,
  output logic             round_ovf,
  output logic [15:0]      stat_inexact_cnt,
  input  logic             stat_clr
);

  localparam int KEEP_W = $clog2(OUT_W + 1);
  localparam int SUM_W  = OUT_W + 1;
  localparam logic [KEEP_W-1:0] OUT_W_K = KEEP_W'(OUT_W);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t              state;
  logic [EXT_MSB:0]    mant_q;
  logic [K_W-1:0]      k_q;
  logic [1:0]          mode_q;
  logic [KEEP_W-1:0]   keep_q;
  logic [OUT_W-1:0]    kept_q;
  logic                guard_q;
  logic                sticky_q;
  logic                lsb_q;

  // Field-width computation on the latched beat
  logic signed [31:0]  k_ext;
  logic signed [31:0]  nbt;
  logic [KEEP_W-1:0]   keep_c;
  logic [OUT_W-1:0]    ext_c;
  logic [OUT_W-1:0]    mask_c;
  logic [OUT_W-1:0]    tail_c;
  logic [OUT_W-1:0]    below_c;
  logic                low_c;
  logic                guard_c;
  logic                sticky_c;
  logic                lsb_c;

  assign k_ext = {{(32-K_W){k_q[K_W-1]}}, k_q};
  assign nbt   = k_q[K_W-1] ? (FRAC_BASE + 1 + k_ext) : (FRAC_BASE - k_ext);

  always_comb begin
    keep_c = '0;
    if (nbt > OUT_W)
      keep_c = OUT_W_K;
    else if (nbt > 0)
      keep_c = nbt[KEEP_W-1:0];
  end

  // tail_c marks discarded window bits; the top one is guard, the rest feed sticky
  assign ext_c    = mant_q[EXT_MSB -: OUT_W];
  assign low_c    = |mant_q[EXT_MSB-OUT_W:0];
  assign mask_c   = ~({OUT_W{1'b1}} >> keep_c);
  assign tail_c   = ~mask_c;
  assign below_c  = tail_c >> 1;
  assign guard_c  = |(ext_c & tail_c & ~below_c);
  assign sticky_c = (|(ext_c & below_c)) | low_c;
  assign lsb_c    = |(ext_c & mask_c & ~(mask_c << 1));

  // Increment; an empty field never rounds up
  logic             inc_c;
  logic [SUM_W-1:0] inc_vec;
  logic [SUM_W-1:0] sum_c;

  always_comb begin
    inc_c = 1'b0;
    case (mode_q)
      2'd1:    inc_c = guard_q & (sticky_q | lsb_q);
      2'd2:    inc_c = guard_q;
      default: inc_c = 1'b0;
    endcase
    if (keep_q == '0)
      inc_c = 1'b0;
  end

  assign inc_vec = SUM_W'(inc_c) << (OUT_W_K - keep_q);
  assign sum_c   = {1'b0, kept_q} + inc_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mant_out  <= '0;
      inexact   <= 1'b0;
      round_ovf <= 1'b0;
      mant_q    <= '0;
      k_q       <= '0;
      mode_q    <= '0;
      keep_q    <= '0;
      kept_q    <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      lsb_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mant_q   <= mant_in[EXT_MSB:0];
            k_q      <= k_in;
            mode_q   <= rnd_mode;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          keep_q   <= keep_c;
          kept_q   <= ext_c & mask_c;
          guard_q  <= guard_c;
          sticky_q <= sticky_c;
          lsb_q    <= lsb_c;
          state    <= ROUND;
        end
        ROUND: begin
          mant_out  <= sum_c[OUT_W-1:0];
          round_ovf <= sum_c[OUT_W];
          inexact   <= guard_q | sticky_q;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (IN_W - 1 > EXT_MSB) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^mant_in[IN_W-1:EXT_MSB+1];
    end
  endgenerate

`ifdef POSIT_ROUND_STATS_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (stat_clr)
      cnt <= '0;
    else if (state == DONE && out_ready && inexact && cnt != 16'hFFFF)
      cnt <= cnt + 16'd1;
  end

  assign stat_inexact_cnt = cnt;
`else
  logic unused_clr;
  assign unused_clr       = stat_clr;
  assign stat_inexact_cnt = '0;
`endif

endmodule

// File: tb/tb_posit_frac_round.sv
// Directed-vector bench for posit_frac_round: hand-computed results, latency, DONE hold, reset abort, counter.
module tb_posit_frac_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] mant_in;
  logic [5:0]  k_in;
  logic [1:0]  rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] mant_out;
  logic        inexact;
  logic        round_ovf;
  logic [15:0] stat_inexact_cnt;
  logic        stat_clr;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  posit_frac_round dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .mant_in(mant_in), .k_in(k_in), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant_out(mant_out), .inexact(inexact), .round_ovf(round_ovf),
    .stat_inexact_cnt(stat_inexact_cnt), .stat_clr(stat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One full transaction: present, measure latency, check result, accept.
  task automatic run_vec(input string tag, input logic [1:0] hi, input logic [5:0] k,
                         input logic [1:0] mode, input logic [31:0] win, input logic [29:0] low,
                         input logic [31:0] e_out, input logic e_inx, input logic e_ovf);
    int lat;
    @(negedge clk);
    mant_in  = {hi, win, low};
    k_in     = k;
    rnd_mode = mode;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, ".lat"}, 64'(lat), 64'd3);
    check({tag, ".mant_out"}, 64'(mant_out), 64'(e_out));
    check({tag, ".inexact"}, 64'(inexact), 64'(e_inx));
    check({tag, ".round_ovf"}, 64'(round_ovf), 64'(e_ovf));
    check({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
    $display("txn %s: k=%h mode=%0d win=%h low=%h -> mant_out=%h inexact=%0b ovf=%0b lat=%0d",
             tag, k, mode, win, low, mant_out, inexact, round_ovf, lat);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if (e_inx) exp_cnt++;
    check({tag, ".out_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    check({tag, ".mant_out_hold"}, 64'(mant_out), 64'(e_out));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int wait_cnt;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mant_in   = '0;
    k_in      = '0;
    rnd_mode  = '0;
    out_ready = 1'b0;
    stat_clr  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.mant_out", 64'(mant_out), 64'd0);
    check("rst.inexact", 64'(inexact), 64'd0);
    check("rst.round_ovf", 64'(round_ovf), 64'd0);
    check("rst.cnt", 64'(stat_inexact_cnt), 64'd0);
    rst_n = 1'b1;

    //        tag         hi     k      mode  window         low    out           inx   ovf
    run_vec("k0_trunc",  2'b00, 6'h00, 2'd0, 32'hFFFF_FFC0, 30'h0, 32'hFFFF_FFC0, 1'b0, 1'b0);
    run_vec("k0_rne_60", 2'b00, 6'h00, 2'd1, 32'h0000_0060, 30'h0, 32'h0000_0080, 1'b1, 1'b0);
    run_vec("k0_trn_60", 2'b00, 6'h00, 2'd0, 32'h0000_0060, 30'h0, 32'h0000_0040, 1'b1, 1'b0);
    run_vec("k0_rne_ov", 2'b00, 6'h00, 2'd1, 32'hFFFF_FFE0, 30'h0, 32'h0000_0000, 1'b1, 1'b1);
    run_vec("km3_tie",   2'b00, 6'h3D, 2'd1, 32'h1234_5680, 30'h0, 32'h1234_5600, 1'b1, 1'b0);
    run_vec("kp31_k0",   2'b00, 6'h1F, 2'd1, 32'h0000_0000, 30'h1, 32'h0000_0000, 1'b1, 1'b0);
    run_vec("km32_rha",  2'b00, 6'h20, 2'd2, 32'h8000_0000, 30'h0, 32'h0000_0000, 1'b1, 1'b0);
    run_vec("km32_hi",   2'b11, 6'h20, 2'd0, 32'h0000_0000, 30'h0, 32'h0000_0000, 1'b0, 1'b0);
    run_vec("k0_rha_20", 2'b00, 6'h00, 2'd2, 32'h0000_0020, 30'h0, 32'h0000_0040, 1'b1, 1'b0);
    run_vec("k0_rne_20", 2'b00, 6'h00, 2'd1, 32'h0000_0020, 30'h0, 32'h0000_0000, 1'b1, 1'b0);
    run_vec("k0_rne_st", 2'b00, 6'h00, 2'd1, 32'h0000_0020, 30'h1, 32'h0000_0040, 1'b1, 1'b0);
    run_vec("k0_mode3",  2'b00, 6'h00, 2'd3, 32'h0000_007F, 30'h0, 32'h0000_0040, 1'b1, 1'b0);
    run_vec("k5_rne",    2'b00, 6'h05, 2'd1, 32'h0000_0400, 30'h0, 32'h0000_0000, 1'b1, 1'b0);
    run_vec("k5_rha",    2'b00, 6'h05, 2'd2, 32'h0000_0400, 30'h0, 32'h0000_0800, 1'b1, 1'b0);
    run_vec("km27_k0",   2'b00, 6'h25, 2'd1, 32'h0000_0001, 30'h0, 32'h0000_0000, 1'b1, 1'b0);
    run_vec("km26_k1",   2'b00, 6'h26, 2'd1, 32'h7FFF_FFFF, 30'h0, 32'h8000_0000, 1'b1, 1'b0);
    run_vec("km26_ov",   2'b00, 6'h26, 2'd1, 32'hC000_0000, 30'h0, 32'h0000_0000, 1'b1, 1'b1);

    // DONE held for 5 cycles while extra beats are offered
    @(negedge clk);
    mant_in  = {2'b00, 32'h0000_0060, 30'h0};
    k_in     = 6'h00;
    rnd_mode = 2'd1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 12) begin
      @(negedge clk);
      wait_cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      mant_in  = {2'b00, 32'hFFFF_FFFF, 30'h3FFF_FFFF};
      check("hold.out_valid", 64'(out_valid), 64'd1);
      check("hold.in_ready", 64'(in_ready), 64'd0);
      check("hold.mant_out", 64'(mant_out), 64'h80);
      check("hold.inexact", 64'(inexact), 64'd1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("hold.dropped_beat", 64'(seen), 64'd0);
    check("hold.mant_after", 64'(mant_out), 64'h80);
    $display("txn hold: 5 stalled cycles, extra beats offered, mant_out=%h", mant_out);

    // Reset asserted while the block is in ROUND
    @(negedge clk);
    mant_in  = {2'b00, 32'hFFFF_FFC0, 30'h0};
    k_in     = 6'h00;
    rnd_mode = 2'd0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort.in_ready", 64'(in_ready), 64'd1);
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check("abort.mant_out", 64'(mant_out), 64'd0);
    check("abort.inexact", 64'(inexact), 64'd0);
    check("abort.round_ovf", 64'(round_ovf), 64'd0);
    check("abort.cnt", 64'(stat_inexact_cnt), 64'd0);
    exp_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn abort: reset during ROUND, mant_out=%h out_valid=%0b", mant_out, out_valid);

    run_vec("post_rst",  2'b00, 6'h00, 2'd1, 32'h0000_0060, 30'h0, 32'h0000_0080, 1'b1, 1'b0);

`ifdef POSIT_ROUND_STATS_EN
    check("stat.cnt", 64'(stat_inexact_cnt), 64'(exp_cnt));
`else
    check("stat.cnt", 64'(stat_inexact_cnt), 64'd0);
`endif
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    check("stat.clr", 64'(stat_inexact_cnt), 64'd0);
    $display("txn stats: cnt=%0d after clear", stat_inexact_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/posit_frac_round.md
Name: posit_frac_round

Overview:
Parametrised fraction-field rounding unit for the posit encode path. Sits after the regime/exponent shifter and before final packing. Takes the aligned mantissa and the signed regime value k, computes how many fraction bits fit, keeps that many MSBs of the extraction window, and rounds the rest per a selectable mode. Uses a valid/ready handshake on both sides and reports inexact and rounding-carry status.

Parameters:
IN_W, 64, width of the aligned mantissa input
OUT_W, 32, width of the extraction window and the rounded output
K_W, 6, width of the two's-complement regime value k
EXT_MSB, 61, MSB index of the extraction window in the mantissa; window is [EXT_MSB : EXT_MSB-OUT_W+1]
FRAC_BASE, 26, fraction bits available when k=0

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat; high only in IDLE
mant_in  input  IN_W  aligned mantissa
k_in  input  K_W  signed regime value
rnd_mode  input  2  rounding mode: 0 truncate, 1 round-to-nearest-even, 2 round-half-away, 3 treated as truncate
out_valid  output  1  result valid; held until accepted
out_ready  input  1  downstream accepts result
mant_out  output  OUT_W  masked and rounded fraction window
inexact  output  1  at least one discarded bit was non-zero
round_ovf  output  1  rounding increment carried out of the window
stat_inexact_cnt  output  16  inexact-result counter; see Optional Feature
stat_clr  input  1  synchronous clear for the counter

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=1, out_valid=0, mant_out=0, inexact=0, round_ovf=0, stat_inexact_cnt=0. All internal registers are cleared.
- States: IDLE -> CALC -> ROUND -> DONE -> IDLE.
- IDLE: in_ready=1. When in_valid=1, latch mant_in, k_in and rnd_mode, then go to CALC.
- CALC: compute the field width in signed arithmetic of at least K_W+2 bits.
  - nbt = FRAC_BASE - k if k >= 0; otherwise nbt = FRAC_BASE + 1 + k.
  - keep = clamp(nbt, 0, OUT_W).
  - ext = window bits of the latched mantissa.
  - mask has the top keep bits set.
  - guard = ext[OUT_W-1-keep] when keep < OUT_W, else 0.
  - sticky = OR of ext bits below guard, ORed with mant_in[EXT_MSB-OUT_W:0].
  - lsb = ext[OUT_W-keep] when keep > 0.
  - All of these are registered.
- ROUND: compute the increment.
  - inc = 0 for truncate.
  - inc = guard & (sticky | lsb) for round-to-nearest-even.
  - inc = guard for round-half-away.
  - sum = (ext & mask) + (inc << (OUT_W-keep)), computed OUT_W+1 wide.
  - mant_out = sum[OUT_W-1:0]; round_ovf = sum[OUT_W].
  - inexact = guard | sticky.
- keep = 0: mant_out = 0, round_ovf = 0, no increment. inexact = OR of the window and all lower bits.
- keep = OUT_W: guard = 0; sticky comes only from the bits below the window.
- DONE: out_valid=1 with outputs stable until out_ready=1. On acceptance, go to IDLE and drop out_valid in the next cycle.
- Latency: with out_ready=1, out_valid rises 3 cycles after the accepting edge. Throughput is one result per 4 cycles.
- in_valid is ignored outside IDLE. mant_out, inexact and round_ovf hold their values after acceptance until the next ROUND.
- Reset asserted in any state aborts the operation and returns all outputs to their reset values.

Optional Feature:
Macro: POSIT_ROUND_STATS_EN.
- Defined: stat_inexact_cnt increments by 1 on each DONE acceptance with inexact=1. It saturates at 16'hFFFF. stat_clr=1 zeroes it and takes priority over an increment in the same cycle.
- Undefined: stat_inexact_cnt is tied to 0, stat_clr is ignored, and no counter logic is built.

Test Plan:
- k=0, window=32'hFFFF_FFC0, lower bits 0, mode 0 -> mant_out=32'hFFFF_FFC0, inexact=0, round_ovf=0; out_valid 3 cycles after accept.
- k=0, window=32'h0000_0060, lower bits 0: mode 1 -> 32'h0000_0080, inexact=1; mode 0 -> 32'h0000_0040, inexact=1.
- k=0, window=32'hFFFF_FFE0, mode 1 -> mant_out=0, round_ovf=1, inexact=1.
- k=-3 (6'b111101), keep=24, window=32'h1234_5680, lower bits 0, mode 1 -> 32'h1234_5600 (tie with even LSB, no increment), inexact=1.
- k=+31 and k=-32 -> keep=0 -> mant_out=0; inexact=1 iff the mantissa from the window MSB down is non-zero.
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid: outputs stay stable, in_ready=0, the extra beat is dropped. Assert rst_n=0 during ROUND: outputs return to reset values, state is IDLE.
